// File: rtl/mcu51_pkg.sv
// +-----------------------------------------------------------------------+
// | mcu51_pkg : ALUCode encodings, sequencer commands and FSM states       |
// | Revision  : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

package mcu51_pkg;

  localparam logic [3:0] ALU_INC  = 4'h0;
  localparam logic [3:0] ALU_DEC  = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_ADDC = 4'h3;
  localparam logic [3:0] ALU_ORL  = 4'h4;
  localparam logic [3:0] ALU_ANL  = 4'h5;
  localparam logic [3:0] ALU_XRL  = 4'h6;
  localparam logic [3:0] ALU_CPL  = 4'h7;
  localparam logic [3:0] ALU_DA   = 4'h8;
  localparam logic [3:0] ALU_SUBB = 4'h9;
  localparam logic [3:0] ALU_RR   = 4'hA;
  localparam logic [3:0] ALU_RRC  = 4'hB;
  localparam logic [3:0] ALU_RL   = 4'hC;
  localparam logic [3:0] ALU_RLC  = 4'hD;

  localparam logic [4:0] CMD_MUL = 5'h10;
  localparam logic [4:0] CMD_DIV = 5'h11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Signed overflow for the add/subtract family; every other code keeps PSW.OV.
  function automatic logic calc_ov(input logic [3:0] code, input logic a7,
                                   input logic b7, input logic r7, input logic ov_in);
    logic ov;
    ov = ov_in;
    if (code == ALU_ADD || code == ALU_ADDC)
      ov = (a7 == b7) && (r7 != a7);
    else if (code == ALU_SUBB)
      ov = (a7 != b7) && (r7 != a7);
    return ov;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer.sv
// +-----------------------------------------------------------------------+
// | alu_sequencer : MCU51 execute-stage ALU controller, MUL/DIV sequencer  |
// | Revision      : 1.0                                                    |
// +-----------------------------------------------------------------------+
`default_nettype none

module alu_sequencer
  import mcu51_pkg::*;
#(
  parameter int ITER = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] cmd,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       cy_in,
  input  logic       ac_in,
  input  logic       ov_in,
  output logic [3:0] alu_code,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cy,
  output logic       alu_ac,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_acarry,
  output logic       busy,
  output logic       done,
  output logic [7:0] res_a,
  output logic [7:0] res_b,
  output logic       cy,
  output logic       ac,
  output logic       ov,
  output logic       p,
  output logic       we_a,
  output logic       we_b,
  output logic       we_psw
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ITER - 1);

  // r_h/r_l/r_m hold H/L/M during MUL and R/Q/D during DIV.
  state_t           r_state;
  logic [7:0]       r_h, r_l, r_m;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_res_a, r_res_b;
  logic             r_cy, r_ac, r_ov;
  logic             r_done, r_we_a, r_we_b, r_we_psw;

  state_t           w_state;
  logic [7:0]       w_h, w_l, w_m;
  logic [CNT_W-1:0] w_cnt;
  logic [7:0]       w_res_a, w_res_b;
  logic             w_cy, w_ac, w_ov;
  logic             w_done, w_we_a, w_we_b, w_we_psw;

  logic [8:0]       w_mul_sum;
  logic [7:0]       w_mul_h, w_mul_l;
  logic [7:0]       w_div_rsh;
  logic             w_div_take;
  logic [7:0]       w_div_r, w_div_q;

  // MUL step: conditional add of M into H, then shift {c,H,L} right by one.
  assign w_mul_sum = r_l[0] ? {alu_carry, alu_result} : {1'b0, r_h};
  assign w_mul_h   = w_mul_sum[8:1];
  assign w_mul_l   = {w_mul_sum[0], r_l[7:1]};

  // DIV step: restoring division; a shifted-out MSB means R' >= D regardless of borrow.
  assign w_div_rsh  = {r_h[6:0], r_l[7]};
  assign w_div_take = r_h[7] | ~alu_carry;
  assign w_div_r    = w_div_take ? alu_result : w_div_rsh;
  assign w_div_q    = {r_l[6:0], w_div_take};

  always_comb begin
    alu_code = cmd[3:0];
    alu_a    = op_a;
    alu_b    = op_b;
    alu_cy   = cy_in;
    alu_ac   = ac_in;
    case (r_state)
      ST_MUL: begin
        alu_code = ALU_ADD;
        alu_a    = r_h;
        alu_b    = r_m;
        alu_cy   = 1'b0;
        alu_ac   = 1'b0;
      end
      ST_DIV: begin
        alu_code = ALU_SUBB;
        alu_a    = w_div_rsh;
        alu_b    = r_m;
        alu_cy   = 1'b0;
        alu_ac   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state  = r_state;
    w_h      = r_h;
    w_l      = r_l;
    w_m      = r_m;
    w_cnt    = r_cnt;
    w_res_a  = r_res_a;
    w_res_b  = r_res_b;
    w_cy     = r_cy;
    w_ac     = r_ac;
    w_ov     = r_ov;
    w_done   = 1'b0;
    w_we_a   = 1'b0;
    w_we_b   = 1'b0;
    w_we_psw = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (cmd == CMD_MUL) begin
            w_state = ST_MUL;
            w_h     = 8'h00;
            w_l     = op_a;
            w_m     = op_b;
            w_cnt   = '0;
          end else if (cmd == CMD_DIV) begin
            if (op_b == 8'h00) begin
              w_done   = 1'b1;
              w_we_psw = 1'b1;
              w_cy     = 1'b0;
              w_ov     = 1'b1;
              w_ac     = ac_in;
            end else begin
              w_state = ST_DIV;
              w_h     = 8'h00;
              w_l     = op_a;
              w_m     = op_b;
              w_cnt   = '0;
            end
          end else if (!cmd[4]) begin
            w_res_a  = alu_result;
            w_cy     = alu_carry;
            w_ac     = alu_acarry;
            w_ov     = calc_ov(cmd[3:0], op_a[7], op_b[7], alu_result[7], ov_in);
            w_done   = 1'b1;
            w_we_a   = 1'b1;
            w_we_psw = 1'b1;
          end else begin
            w_done = 1'b1;
          end
        end
      end

      ST_MUL: begin
        w_h   = w_mul_h;
        w_l   = w_mul_l;
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == C_CNT_LAST) begin
          w_state  = ST_IDLE;
          w_res_a  = w_mul_l;
          w_res_b  = w_mul_h;
          w_cy     = 1'b0;
          w_ov     = (w_mul_h != 8'h00);
          w_ac     = ac_in;
          w_done   = 1'b1;
          w_we_a   = 1'b1;
          w_we_b   = 1'b1;
          w_we_psw = 1'b1;
        end
      end

      ST_DIV: begin
        w_h   = w_div_r;
        w_l   = w_div_q;
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == C_CNT_LAST) begin
          w_state  = ST_IDLE;
          w_res_a  = w_div_q;
          w_res_b  = w_div_r;
          w_cy     = 1'b0;
          w_ov     = 1'b0;
          w_ac     = ac_in;
          w_done   = 1'b1;
          w_we_a   = 1'b1;
          w_we_b   = 1'b1;
          w_we_psw = 1'b1;
        end
      end

      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_h      <= 8'h00;
      r_l      <= 8'h00;
      r_m      <= 8'h00;
      r_cnt    <= '0;
      r_res_a  <= 8'h00;
      r_res_b  <= 8'h00;
      r_cy     <= 1'b0;
      r_ac     <= 1'b0;
      r_ov     <= 1'b0;
      r_done   <= 1'b0;
      r_we_a   <= 1'b0;
      r_we_b   <= 1'b0;
      r_we_psw <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_h      <= w_h;
      r_l      <= w_l;
      r_m      <= w_m;
      r_cnt    <= w_cnt;
      r_res_a  <= w_res_a;
      r_res_b  <= w_res_b;
      r_cy     <= w_cy;
      r_ac     <= w_ac;
      r_ov     <= w_ov;
      r_done   <= w_done;
      r_we_a   <= w_we_a;
      r_we_b   <= w_we_b;
      r_we_psw <= w_we_psw;
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign res_a  = r_res_a;
  assign res_b  = r_res_b;
  assign cy     = r_cy;
  assign ac     = r_ac;
  assign ov     = r_ov;
  assign p      = ^r_res_a;
  assign we_a   = r_we_a;
  assign we_b   = r_we_b;
  assign we_psw = r_we_psw;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// +-----------------------------------------------------------------------+
// | tb_alu_sequencer : directed bench with a behavioural MCU51 ALU model   |
// | Revision         : 1.0                                                 |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_alu_sequencer;
  import mcu51_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] cmd;
  logic [7:0] op_a, op_b;
  logic       cy_in, ac_in, ov_in;
  logic [3:0] alu_code;
  logic [7:0] alu_a, alu_b;
  logic       alu_cy, alu_ac;
  logic [7:0] alu_result;
  logic       alu_carry, alu_acarry;
  logic       busy, done;
  logic [7:0] res_a, res_b;
  logic       cy, ac, ov, p;
  logic       we_a, we_b, we_psw;

  int n_checks = 0;
  int n_pass   = 0;

  alu_sequencer #(.ITER(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
    .op_a(op_a), .op_b(op_b), .cy_in(cy_in), .ac_in(ac_in), .ov_in(ov_in),
    .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cy(alu_cy), .alu_ac(alu_ac),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_acarry(alu_acarry),
    .busy(busy), .done(done), .res_a(res_a), .res_b(res_b),
    .cy(cy), .ac(ac), .ov(ov), .p(p),
    .we_a(we_a), .we_b(we_b), .we_psw(we_psw)
  );

  always #5 clk = ~clk;

  // Reference ALU: only the codes the sequencer is exercised with here.
  logic [8:0] m_full;
  logic [4:0] m_nib;
  always_comb begin
    m_full = {alu_cy, alu_a};
    m_nib  = {alu_ac, 4'h0};
    case (alu_code)
      ALU_INC:  m_full = {alu_cy, alu_a + 8'h01};
      ALU_ADD: begin
        m_full = {1'b0, alu_a} + {1'b0, alu_b};
        m_nib  = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]};
      end
      ALU_ADDC: begin
        m_full = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cy};
        m_nib  = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, alu_cy};
      end
      ALU_SUBB: begin
        m_full = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cy};
        m_nib  = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'h0, alu_cy};
      end
      default: ;
    endcase
    alu_result = m_full[7:0];
    alu_carry  = m_full[8];
    alu_acarry = m_nib[4];
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic aci, input logic ovi);
    cmd = c; op_a = a; op_b = b; cy_in = ci; ac_in = aci; ov_in = ovi;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a = 8'hAA;
    op_b = 8'h55;
  endtask

  int n_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; cmd = 5'h00;
    op_a = 8'h00; op_b = 8'h00; cy_in = 1'b0; ac_in = 1'b0; ov_in = 1'b0;
    tick(); tick();
    chk("rst_busy_done", 16'({busy, done}), 16'h0);
    chk("rst_res", {res_a, res_b}, 16'h0000);
    chk("rst_flags", 16'({cy, ac, ov, p}), 16'h0);
    chk("rst_we", 16'({we_a, we_b, we_psw}), 16'h0);
    rst_n = 1'b1;
    tick();

    issue({1'b0, ALU_ADD}, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("add_done", 16'(done), 16'h1);
    chk("add_res", 16'(res_a), 16'h0080);
    chk("add_flags", 16'({cy, ac, ov, p}), 16'b0111);
    chk("add_we", 16'({we_a, we_b, we_psw}), 16'b101);
    tick();
    chk("add_done_pulse", 16'(done), 16'h0);

    issue({1'b0, ALU_SUBB}, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("subb_res", 16'(res_a), 16'h00FF);
    chk("subb_flags", 16'({cy, ac, ov, p}), 16'b1100);

    issue({1'b0, ALU_INC}, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("inc_res_ov", 16'({res_a, 7'h0, ov}), 16'h8001);

    issue(CMD_MUL, 8'h50, 8'hA0, 1'b1, 1'b0, 1'b0);
    chk("mul1_busy_n1", 16'({busy, done}), 16'b10);
    repeat (7) tick();
    chk("mul1_busy_n8", 16'({busy, done}), 16'b10);
    tick();
    chk("mul1_done_n9", 16'({busy, done}), 16'b01);
    chk("mul1_res", {res_a, res_b}, 16'h0032);
    chk("mul1_flags", 16'({cy, ov}), 16'b01);
    chk("mul1_we", 16'({we_a, we_b, we_psw}), 16'b111);

    issue(CMD_MUL, 8'h0F, 8'h03, 1'b0, 1'b1, 1'b1);
    repeat (8) tick();
    chk("mul2_done", 16'(done), 16'h1);
    chk("mul2_res", {res_a, res_b}, 16'h2D00);
    chk("mul2_flags", 16'({cy, ac, ov}), 16'b010);

    issue(CMD_DIV, 8'hFB, 8'h12, 1'b1, 1'b0, 1'b1);
    repeat (8) tick();
    chk("div1_done", 16'(done), 16'h1);
    chk("div1_res", {res_a, res_b}, 16'h0D11);
    chk("div1_flags", 16'({cy, ov}), 16'b00);
    chk("div1_we", 16'({we_a, we_b, we_psw}), 16'b111);

    issue(CMD_DIV, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("div0_done", 16'({busy, done}), 16'b01);
    chk("div0_flags", 16'({cy, ov}), 16'b01);
    chk("div0_we", 16'({we_a, we_b, we_psw}), 16'b001);

    issue(CMD_MUL, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    cmd = {1'b0, ALU_ADD}; op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ignore_n4", 16'({busy, done}), 16'b10);
    repeat (5) tick();
    chk("ignore_done", 16'(done), 16'h1);
    chk("ignore_res", {res_a, res_b}, 16'h0F00);
    issue(CMD_DIV, 8'h64, 8'h07, 1'b0, 1'b0, 1'b0);
    chk("b2b_accept", 16'({busy, done}), 16'b10);
    repeat (8) tick();
    chk("b2b_done", 16'(done), 16'h1);
    chk("b2b_res", {res_a, res_b}, 16'h0E02);

    issue(CMD_MUL, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy_done", 16'({busy, done}), 16'h0);
    chk("abort_res", {res_a, res_b}, 16'h0000);
    chk("abort_flags_we", 16'({cy, ac, ov, p, we_a, we_b, we_psw}), 16'h0);
    tick();
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("abort_no_done", 16'(n_done), 16'h0);

    issue({1'b0, ALU_ADD}, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    chk("post_add_done", 16'(done), 16'h1);
    chk("post_add_res", 16'(res_a), 16'h0046);
    chk("post_add_flags", 16'({cy, ac, ov, p}), 16'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Execute-stage controller that owns the MCU51 ALU. It issues single-cycle ALU operations and sequences the multi-cycle MUL AB and DIV AB instructions as 8 iterations each through the ALU's add/subtract path. It computes OV and parity, which the ALU does not produce, and presents registered results, a done pulse and write enables for ACC, B and PSW to the core. The ALU instance sits outside this block and is driven only by it.

Parameters:
ITER, 8, number of MUL/DIV iterations (operand width; fixed 8 for 8051)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  command valid; accepted only when busy=0
cmd  in  5  0x00-0x0F = ALUCode passthrough; 0x10 = MUL AB; 0x11 = DIV AB; others = NOP
op_a  in  8  first operand (ACC for MUL/DIV)
op_b  in  8  second operand (B for MUL/DIV)
cy_in, ac_in, ov_in  in  1 each  current PSW flags
alu_code  out  4  to ALU ALUCode
alu_a, alu_b  out  8 each  to ALU A, B
alu_cy, alu_ac  out  1 each  to ALU Cy, AC
alu_result  in  8  from ALU Result
alu_carry, alu_acarry  in  1 each  from ALU Carry, AssistantCarry
busy  out  1  high while MUL/DIV is iterating
done  out  1  one-cycle pulse, results valid
res_a, res_b  out  8 each  result for ACC and B
cy, ac, ov, p  out  1 each  new flags; p = XOR of res_a
we_a, we_b, we_psw  out  1 each  qualified by done

Behaviour:
- Reset: state=IDLE. busy, done, we_* = 0. res_a, res_b = 0x00. cy, ac, ov, p = 0. A reset during MUL/DIV aborts the operation with no done pulse.
- IDLE: alu_* driven combinationally from cmd[3:0], op_a, op_b, cy_in, ac_in.
- Single op (cmd<0x10), start at cycle n:
  - Results are registered; done=1 and we_a=we_psw=1 in cycle n+1. we_b=0.
  - cy, ac taken from the ALU.
  - ov computed for ADD/ADDC: (A7==B7)&(R7!=A7). For SUBB: (A7!=B7)&(R7!=A7). INC/DEC and all other codes: ov=ov_in.
- MUL (0x10): state MUL.
  - Init: H=0, L=op_a, M=op_b, cnt=0.
  - Each cycle: alu_code=ADD, alu_a=H, alu_b=M, alu_cy=0. If L[0]=1, {c,H}={alu_carry,alu_result}, else c=0. Then {H,L}={c,H,L}>>1. cnt++.
  - After ITER iterations: res_a=L, res_b=H, cy=0, ov=(H!=0), ac=ac_in. done in cycle n+ITER+1; we_a=we_b=we_psw=1.
- DIV (0x11): state DIV.
  - op_b==0: no iteration. done at n+1, ov=1, cy=0, we_a=we_b=0, we_psw=1.
  - Otherwise init: R=0, Q=op_a, D=op_b.
  - Each cycle: {t,R',Q'}={R,Q}<<1. ALU computes R'-D with alu_code=SUBB, alu_cy=0. If t=1 or alu_carry=0, then R=alu_result and Q'[0]=1; else R=R' and Q'[0]=0.
  - After ITER iterations: res_a=Q, res_b=R, cy=0, ov=0, ac=ac_in. done at n+ITER+1.
- start while busy=1 is ignored, with no queueing. NOP commands give done with all we_*=0.
- In MUL/DIV, the ALU inputs come only from internal registers; op_a and op_b may change after acceptance.
- The done cycle returns to IDLE. A new start is accepted in the same cycle done is high (back-to-back).
- p is always XOR-reduce of res_a.

Decomposition:
- Shared package mcu51_pkg: ALUCode constants (inc, dec, add, addc, orl, anl, xrl, cpl, da, subb, rr, rrc, rl, rlc), CMD_MUL=5'h10, CMD_DIV=5'h11, FSM state encoding (IDLE, MUL, DIV).
- No sub-module; the ALU stays a sibling instance wired by the parent.

Test Plan:
- ADD op_a=0x7F op_b=0x01 cy_in=1 -> done at n+1: res_a=0x80, cy=0, ac=1, ov=1, p=1, we_b=0.
- SUBB op_a=0x00 op_b=0x01 cy_in=0 -> res_a=0xFF, cy=1, ac=1, ov=0, p=0.
- MUL 0x50*0xA0 -> busy for 8 cycles, done at n+9: res_a=0x00, res_b=0x32, ov=1, cy=0. Also MUL 0x0F*0x03 -> 0x2D/0x00, ov=0.
- DIV 0xFB/0x12 -> res_a=0x0D, res_b=0x11, ov=0, cy=0. DIV by 0x00 -> done at n+1, ov=1, we_a=we_b=0.
- Start MUL, assert second start at n+3 -> ignored. Start DIV in the same cycle as MUL done -> accepted, done 9 cycles later.
- rst_n low at n+4 of MUL -> busy=0 and all outputs 0 immediately. No done pulse. Next ADD works normally.
